// File: rtl/alu_resp_checker_if.sv
// Handshake and result bundle between an ALU stimulus source and the
// response checker.
interface alu_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             vec_valid;
    logic [3:0]       A;
    logic [3:0]       B;
    logic [2:0]       S;
    logic [3:0]       out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic             ff_valid;
    logic [3:0]       ff_A;
    logic [3:0]       ff_B;
    logic [2:0]       ff_S;
    logic [3:0]       ff_out;
    logic [3:0]       ff_exp;

    modport master (
        output start, num_vec, vec_valid, A, B, S, out,
        input  busy, done, pass, vec_count, err_count,
        input  ff_valid, ff_A, ff_B, ff_S, ff_out, ff_exp
    );

    modport slave (
        input  start, num_vec, vec_valid, A, B, S, out,
        output busy, done, pass, vec_count, err_count,
        output ff_valid, ff_A, ff_B, ff_S, ff_out, ff_exp
    );
endinterface

// File: rtl/alu_resp_checker.sv
// Checks observed 4-bit ALU results against a golden model over a run of
// num_vec vectors, counting mismatches and capturing the first failure.
module alu_resp_checker #(
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    alu_resp_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] ecnt;
    logic             drain_cnt;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic             s1_valid;
    logic [3:0]       s1_a;
    logic [3:0]       s1_b;
    logic [2:0]       s1_s;
    logic [3:0]       s1_out;

    logic             ffv;
    logic [3:0]       ff_a;
    logic [3:0]       ff_b;
    logic [2:0]       ff_s;
    logic [3:0]       ff_o;
    logic [3:0]       ff_e;

    logic [3:0]       exp_res;
    logic             mis;
    logic [CNT_W-1:0] vcnt_nxt;

    always_comb begin
        exp_res = 4'h0;
        unique case (s1_s)
            3'd0: exp_res = s1_a + s1_b;
            3'd1: exp_res = s1_a - s1_b;
            3'd2: exp_res = s1_a & s1_b;
            3'd3: exp_res = s1_a | s1_b;
            3'd4: exp_res = s1_a ^ s1_b;
            3'd5: exp_res = ~s1_a;
            3'd6: exp_res = {s1_a[2:0], 1'b0};
            3'd7: exp_res = {1'b0, s1_a[3:1]};
            default: exp_res = 4'h0;
        endcase
    end

    assign mis      = s1_valid && (s1_out != exp_res);
    assign vcnt_nxt = vcnt + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            num_lat   <= '0;
            vcnt      <= '0;
            ecnt      <= '0;
            drain_cnt <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_a      <= 4'h0;
            s1_b      <= 4'h0;
            s1_s      <= 3'h0;
            s1_out    <= 4'h0;
            ffv       <= 1'b0;
            ff_a      <= 4'h0;
            ff_b      <= 4'h0;
            ff_s      <= 3'h0;
            ff_o      <= 4'h0;
            ff_e      <= 4'h0;
        end else begin
            // stage 2: compare whatever stage 1 captured last edge
            if (mis) begin
                if (ecnt != MAX)
                    ecnt <= ecnt + ONE;
                if (!ffv) begin
                    ffv  <= 1'b1;
                    ff_a <= s1_a;
                    ff_b <= s1_b;
                    ff_s <= s1_s;
                    ff_o <= s1_out;
                    ff_e <= exp_res;
                end
            end
            s1_valid <= 1'b0;

            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        num_lat <= bus.num_vec;
                        vcnt    <= '0;
                        ecnt    <= '0;
                        ffv     <= 1'b0;
                        ff_a    <= 4'h0;
                        ff_b    <= 4'h0;
                        ff_s    <= 3'h0;
                        ff_o    <= 4'h0;
                        ff_e    <= 4'h0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (num_lat == '0) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else if (bus.vec_valid) begin
                        s1_valid <= 1'b1;
                        s1_a     <= bus.A;
                        s1_b     <= bus.B;
                        s1_s     <= bus.S;
                        s1_out   <= bus.out;
                        vcnt     <= vcnt_nxt;
                        if (vcnt_nxt == num_lat) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // two cycles let the last vector's compare settle
                    if (drain_cnt) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= (ecnt == '0);
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.vec_count = vcnt;
    assign bus.err_count = ecnt;
    assign bus.ff_valid  = ffv;
    assign bus.ff_A      = ff_a;
    assign bus.ff_B      = ff_b;
    assign bus.ff_S      = ff_s;
    assign bus.ff_out    = ff_o;
    assign bus.ff_exp    = ff_e;
endmodule

// File: tb/tb_alu_resp_checker.sv
// Randomized and directed bench for alu_resp_checker against a
// run-level behavioural model.
module tb_alu_resp_checker;
    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    alu_resp_checker_if #(.CNT_W(CNT_W)) bus ();

    alu_resp_checker #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int gold(input int a, input int b, input int s);
        case (s)
            0: return (a + b) % 16;
            1: return (a - b + 16) % 16;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 15 - a;
            6: return (a * 2) % 16;
            default: return a / 2;
        endcase
    endfunction

    // Run-level model: which vectors were accepted at which edge, and
    // the edge at which the run stopped accepting.
    typedef struct {
        int a;
        int b;
        int s;
        int o;
        int e;
    } vec_t;

    vec_t q[$];
    int   cyc    = 0;
    bit   active = 0;
    int   st     = 0;
    int   nv     = 0;
    int   d      = -1;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            active = 0;
            d      = -1;
            q.delete();
        end else if (!active || (d >= 0 && cyc > d + 2)) begin
            if (bus.start) begin
                active = 1;
                st     = cyc;
                nv     = int'(bus.num_vec);
                d      = -1;
                q.delete();
            end
        end else if (d < 0) begin
            if (nv == 0) begin
                d = cyc;
            end else if (bus.vec_valid) begin
                q.push_back('{int'(bus.A), int'(bus.B), int'(bus.S),
                              int'(bus.out), cyc});
                if (q.size() == nv)
                    d = cyc;
            end
        end
    end

    always @(negedge clk) begin
        int nerr;
        int first;
        int dn;
        int e_err;
        nerr  = 0;
        first = -1;
        foreach (q[i]) begin
            if (q[i].e < cyc && q[i].o != gold(q[i].a, q[i].b, q[i].s)) begin
                nerr++;
                if (first < 0)
                    first = i;
            end
        end
        e_err = (nerr > SAT) ? SAT : nerr;
        dn    = (active && d >= 0 && cyc >= d + 2) ? 1 : 0;
        chk("busy", int'(bus.busy), (active && dn == 0) ? 1 : 0);
        chk("done", int'(bus.done), dn);
        chk("pass", int'(bus.pass), (dn == 1 && e_err == 0) ? 1 : 0);
        chk("vec_count", int'(bus.vec_count), active ? q.size() : 0);
        chk("err_count", int'(bus.err_count), active ? e_err : 0);
        chk("ff_valid", int'(bus.ff_valid), (active && first >= 0) ? 1 : 0);
        if (active && first >= 0) begin
            chk("ff_A", int'(bus.ff_A), q[first].a);
            chk("ff_B", int'(bus.ff_B), q[first].b);
            chk("ff_S", int'(bus.ff_S), q[first].s);
            chk("ff_out", int'(bus.ff_out), q[first].o);
            chk("ff_exp", int'(bus.ff_exp),
                gold(q[first].a, q[first].b, q[first].s));
        end else begin
            chk("ff_clr", int'({bus.ff_A, bus.ff_B, bus.ff_S,
                               bus.ff_out, bus.ff_exp}), 0);
        end
    end

    task automatic go(input int n);
        bus.start   = 1'b1;
        bus.num_vec = CNT_W'(n);
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int s, input int o);
        bus.vec_valid = 1'b1;
        bus.A         = 4'(a);
        bus.B         = 4'(b);
        bus.S         = 3'(s);
        bus.out       = 4'(o);
        @(negedge clk);
        bus.vec_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(bus.done), 1);
    endtask

    int sweep_ok[8] = '{4, 2, 1, 3, 2, 12, 6, 1};

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.num_vec   = '0;
        bus.vec_valid = 1'b0;
        bus.A         = 4'h0;
        bus.B         = 4'h0;
        bus.S         = 3'h0;
        bus.out       = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({bus.busy, bus.done, bus.pass, bus.vec_count,
                                bus.err_count, bus.ff_valid}), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // vec_valid while idle must be ignored
        send(3, 1, 0, 9);
        chk("idle_vec_ignored", int'(bus.vec_count), 0);

        // clean sweep
        go(8);
        for (int i = 0; i < 8; i++)
            send(3, 1, i, sweep_ok[i]);
        wait_done("sweep_done");
        chk("sweep_vc", int'(bus.vec_count), 8);
        chk("sweep_err", int'(bus.err_count), 0);
        chk("sweep_pass", int'(bus.pass), 1);
        chk("sweep_ffv", int'(bus.ff_valid), 0);

        // faults at S=000 and S=111
        go(8);
        for (int i = 0; i < 8; i++)
            send(3, 1, i, (i == 0) ? 5 : (i == 7) ? 0 : sweep_ok[i]);
        wait_done("fault_done");
        chk("fault_err", int'(bus.err_count), 2);
        chk("fault_pass", int'(bus.pass), 0);
        chk("fault_ffS", int'(bus.ff_S), 0);
        chk("fault_ffout", int'(bus.ff_out), 5);
        chk("fault_ffexp", int'(bus.ff_exp), 4);

        // wrap-around of add and subtract
        go(2);
        send(15, 1, 0, 0);
        send(0, 1, 1, 15);
        wait_done("wrap_done");
        chk("wrap_pass", int'(bus.pass), 1);

        // compare latency and drain length
        go(1);
        bus.vec_valid = 1'b1;
        bus.A = 4'd1; bus.B = 4'd1; bus.S = 3'd0; bus.out = 4'd0;
        @(negedge clk);
        bus.vec_valid = 1'b0;
        chk("lat_err_1clk", int'(bus.err_count), 0);
        @(negedge clk);
        chk("lat_err_2clk", int'(bus.err_count), 1);
        chk("lat_ffexp", int'(bus.ff_exp), 2);
        chk("lat_done_early", int'(bus.done), 0);
        @(negedge clk);
        chk("lat_done", int'(bus.done), 1);

        // vec_valid in DONE, start during RUN, start with final vector
        send(2, 2, 0, 4);
        chk("done_vec_ignored", int'(bus.vec_count), 1);
        go(3);
        send(5, 3, 1, 2);
        go(7);
        send(5, 3, 2, 1);
        bus.start   = 1'b1;
        bus.num_vec = CNT_W'(9);
        send(5, 3, 3, 7);
        bus.start   = 1'b0;
        wait_done("ign_done");
        chk("ign_vc", int'(bus.vec_count), 3);
        chk("ign_pass", int'(bus.pass), 1);

        // empty run
        go(0);
        wait_done("zero_done");
        chk("zero_pass", int'(bus.pass), 1);
        chk("zero_vc", int'(bus.vec_count), 0);

        // reset mid-run, then a normal run
        go(4);
        send(1, 2, 0, 3);
        send(1, 2, 1, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", int'({bus.busy, bus.done, bus.vec_count,
                                  bus.err_count, bus.ff_valid}), 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_stay_idle", int'(bus.busy), 0);
        go(2);
        send(9, 4, 4, 13);
        send(9, 4, 6, 2);
        wait_done("rst_rerun_done");
        chk("rst_rerun_pass", int'(bus.pass), 1);

        // random runs
        for (int r = 0; r < 30; r++) begin
            go($urandom_range(0, 12));
            for (int c = 0; c < 80 && !bus.done; c++) begin
                int a;
                int b;
                int s;
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                s = $urandom_range(0, 7);
                bus.vec_valid = ($urandom_range(0, 9) < 7);
                bus.A   = 4'(a);
                bus.B   = 4'(b);
                bus.S   = 3'(s);
                bus.out = ($urandom_range(0, 3) == 0) ?
                          4'($urandom_range(0, 15)) : 4'(gold(a, b, s));
                bus.start   = ($urandom_range(0, 19) == 0);
                bus.num_vec = CNT_W'($urandom_range(0, 12));
                @(negedge clk);
            end
            bus.vec_valid = 1'b0;
            bus.start     = 1'b0;
            chk("rand_done", int'(bus.done), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
